// File: rtl/seven_segs_scan_decoder.sv
// Snoops a multiplexed active-low seven-segment bus, debounces each digit dwell,
// decodes segments back to BCD and hands complete frames out over valid/ready.
//
// state    | meaning
// S_IDLE   | no legal digit select on the bus
// S_TRACK  | counting consecutive identical samples of the current digit
// S_ACCEPT | dwell is stable: write the decoded nibble (one cycle)
// S_HOLD   | digit already taken for this dwell, wait for the bus to move on
module seven_segs_scan_decoder #(
    parameter int NDIGITS    = 4,
    parameter int STABLE_CNT = 4
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic [6:0]             SevenSegs,
    input  logic [NDIGITS-1:0]     DigitEn,
    output logic [4*NDIGITS-1:0]   BcdOut,
    output logic                   ErrOut,
    output logic                   Valid,
    input  logic                   Ready,
    output logic                   Overrun
);

    localparam int         DW       = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [7:0] CNT_LAST = 8'(STABLE_CNT - 1);
    localparam bit         ONE_SHOT = (STABLE_CNT == 1);

    typedef enum logic [1:0] {S_IDLE, S_TRACK, S_ACCEPT, S_HOLD} state_t;

    state_t                     state_q, state_d;
    logic [6:0]                 seg_m, seg_s, seg_q;
    logic [NDIGITS-1:0]         en_m, en_s, en_low;
    logic                       sel_ok, changed;
    logic [DW-1:0]              sel_idx, d_q;
    logic [7:0]                 cnt_q;
    logic                       load, inc, accept;
    logic [3:0]                 dec_nib;
    logic                       dec_err;
    logic [NDIGITS-1:0][3:0]    digits_q;
    logic [NDIGITS-1:0]         err_q, mask_q;
    logic                       frame_done;

    // Synchronizers come out of reset showing a blank, deselected bus so an
    // idle display never looks like a legal digit select.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            seg_m <= '1;
            seg_s <= '1;
            en_m  <= '1;
            en_s  <= '1;
        end else begin
            seg_m <= SevenSegs;
            seg_s <= seg_m;
            en_m  <= DigitEn;
            en_s  <= en_m;
        end
    end

    always_comb begin
        en_low  = ~en_s;
        sel_ok  = (en_low != '0) && ((en_low & (en_low - NDIGITS'(1))) == '0);
        sel_idx = '0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (en_low[i]) sel_idx = DW'(i);
        end
        changed = (sel_idx != d_q) || (seg_s != seg_q);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (sel_ok) state_d = ONE_SHOT ? S_ACCEPT : S_TRACK;
            end
            S_TRACK: begin
                if (!sel_ok)               state_d = S_IDLE;
                else if (changed)          state_d = S_TRACK;
                else if (cnt_q == CNT_LAST) state_d = S_ACCEPT;
            end
            S_ACCEPT: state_d = S_HOLD;
            S_HOLD: begin
                if (!sel_ok)      state_d = S_IDLE;
                else if (changed) state_d = ONE_SHOT ? S_ACCEPT : S_TRACK;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        load   = 1'b0;
        inc    = 1'b0;
        accept = 1'b0;
        case (state_q)
            S_IDLE:   load = sel_ok;
            S_TRACK: begin
                load = sel_ok && changed;
                inc  = sel_ok && !changed;
            end
            S_ACCEPT: accept = 1'b1;
            S_HOLD:   load = sel_ok && changed;
            default:  ;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            d_q   <= '0;
            seg_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            d_q   <= sel_idx;
            seg_q <= seg_s;
            cnt_q <= 8'd1;
        end else if (inc) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    always_comb begin
        dec_err = 1'b0;
        case (seg_q)
            7'h40:   dec_nib = 4'h0;
            7'h79:   dec_nib = 4'h1;
            7'h24:   dec_nib = 4'h2;
            7'h30:   dec_nib = 4'h3;
            7'h19:   dec_nib = 4'h4;
            7'h12:   dec_nib = 4'h5;
            7'h02:   dec_nib = 4'h6;
            7'h78:   dec_nib = 4'h7;
            7'h00:   dec_nib = 4'h8;
            7'h18:   dec_nib = 4'h9;
            7'h7F:   dec_nib = 4'hA;
            default: begin
                dec_nib = 4'hF;
                dec_err = 1'b1;
            end
        endcase
    end

    assign frame_done = &mask_q;

    // Accept cannot coincide with frame_done: S_ACCEPT is always followed by S_HOLD.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            digits_q <= '0;
            err_q    <= '0;
            mask_q   <= '0;
        end else begin
            if (frame_done) begin
                err_q  <= '0;
                mask_q <= '0;
            end
            if (accept) begin
                digits_q[d_q] <= dec_nib;
                err_q[d_q]    <= dec_err;
                mask_q[d_q]   <= 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            BcdOut  <= '0;
            ErrOut  <= 1'b0;
            Valid   <= 1'b0;
            Overrun <= 1'b0;
        end else if (frame_done) begin
            if (!Valid || Ready) begin
                BcdOut <= digits_q;
                ErrOut <= |err_q;
                Valid  <= 1'b1;
            end else begin
                Overrun <= 1'b1;
            end
        end else if (Valid && Ready) begin
            Valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seven_segs_scan_decoder.sv
// Bench for seven_segs_scan_decoder: directed frame vectors, glitch/select corner
// sequences, handshake and reset cases, then random dwells against a dwell-level model.
module tb_seven_segs_scan_decoder;

    localparam int ND = 4;
    localparam int SC = 4;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic [6:0]  SevenSegs = 7'h7F;
    logic [3:0]  DigitEn = 4'hF;
    logic [15:0] BcdOut;
    logic        ErrOut, Valid, Ready = 1'b1, Overrun;

    seven_segs_scan_decoder #(.NDIGITS(ND), .STABLE_CNT(SC)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .SevenSegs(SevenSegs), .DigitEn(DigitEn),
        .BcdOut(BcdOut), .ErrOut(ErrOut), .Valid(Valid), .Ready(Ready),
        .Overrun(Overrun)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    int t_drive = 0;
    logic [16:0] got_q[$];
    int          got_cyc[$];
    logic [16:0] exp_q[$];

    // Every handshake the DUT completes is recorded as {ErrOut, BcdOut}.
    always @(negedge Clk) begin
        if (Rst_n && Valid && Ready) begin
            got_q.push_back({ErrOut, BcdOut});
            got_cyc.push_back(cyc);
        end
    end

    typedef struct {
        logic [3:0][6:0] pats;
        logic [15:0]     bcd;
        logic            err;
    } vec_t;
    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] sel(input int d);
        logic [3:0] v;
        v = 4'b0001 << d;
        return ~v;
    endfunction

    task automatic drive(input logic [6:0] seg, input logic [3:0] en, input int len);
        @(posedge Clk);
        #1;
        SevenSegs = seg;
        DigitEn   = en;
        t_drive   = cyc;
        repeat (len - 1) @(posedge Clk);
    endtask

    task automatic idle(input int n);
        drive(7'h7F, 4'hF, n);
    endtask

    task automatic scan4(input logic [3:0][6:0] p, input int dwell);
        for (int i = 0; i < 4; i++) drive(p[i], sel(i), dwell);
    endtask

    task automatic expect_frame(input string name, input logic [15:0] bcd, input logic err);
        logic [16:0] g;
        if (got_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: got no frame expected %0h", name, {err, bcd});
        end else begin
            g = got_q.pop_front();
            void'(got_cyc.pop_front());
            check(name, 32'(g), 32'({err, bcd}));
        end
    endtask

    function automatic logic [4:0] model_dec(input logic [6:0] p);
        logic [6:0] tbl [10];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h18};
        for (int i = 0; i < 10; i++) if (p == tbl[i]) return {1'b0, 4'(i)};
        if (p == 7'h7F) return {1'b0, 4'hA};
        return {1'b1, 4'hF};
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t3;
        vecs[0] = '{pats: {7'h19, 7'h79, 7'h24, 7'h30}, bcd: 16'h4123, err: 1'b0};
        vecs[1] = '{pats: {7'h30, 7'h55, 7'h79, 7'h7F}, bcd: 16'h3F1A, err: 1'b1};
        vecs[2] = '{pats: {7'h78, 7'h02, 7'h12, 7'h40}, bcd: 16'h7650, err: 1'b0};
        vecs[3] = '{pats: {7'h40, 7'h7F, 7'h18, 7'h00}, bcd: 16'h0A98, err: 1'b0};

        #12;
        check("reset BcdOut", 32'(BcdOut), 0);
        check("reset ErrOut", 32'(ErrOut), 0);
        check("reset Valid", 32'(Valid), 0);
        check("reset Overrun", 32'(Overrun), 0);
        @(negedge Clk);
        Rst_n = 1'b1;

        // Table-driven complete frames, Ready held high.
        for (int v = 0; v < 4; v++) begin
            scan4(vecs[v].pats, 10);
            t3 = t_drive;
            idle(8);
            check($sformatf("vec%0d frame count", v), 32'(got_q.size()), 1);
            if (v == 0 && got_cyc.size() > 0)
                check("vec0 latency", 32'(got_cyc[0] - t3), 8);
            expect_frame($sformatf("vec%0d frame", v), vecs[v].bcd, vecs[v].err);
        end

        // Glitch on digit 1 before the settled value.
        drive(7'h40, sel(0), 10);
        drive(7'h79, sel(1), 2);
        drive(7'h24, sel(1), 10);
        drive(7'h30, sel(2), 10);
        drive(7'h19, sel(3), 10);
        idle(8);
        expect_frame("glitch frame", 16'h4320, 1'b0);

        // Too-short dwell: digit 1 missing until rescanned.
        drive(7'h40, sel(0), 10);
        drive(7'h79, sel(1), SC - 1);
        drive(7'h30, sel(2), 10);
        drive(7'h19, sel(3), 10);
        idle(8);
        check("short dwell no frame", 32'(got_q.size()), 0);
        drive(7'h12, sel(1), 10);
        idle(8);
        expect_frame("rescan frame", 16'h4350, 1'b0);

        // Multi-hot enables never accept.
        drive(7'h40, sel(0), 10);
        drive(7'h24, sel(1), 10);
        drive(7'h30, sel(2), 10);
        drive(7'h79, 4'b1100, 20);
        idle(4);
        check("multihot no frame", 32'(got_q.size()), 0);
        drive(7'h19, sel(3), 10);
        idle(8);
        expect_frame("multihot frame", 16'h4320, 1'b0);

        // Deselect mid-dwell restarts the count.
        drive(7'h40, sel(0), 2);
        drive(7'h40, 4'hF, 1);
        drive(7'h40, sel(0), 2);
        drive(7'h24, sel(1), 10);
        drive(7'h30, sel(2), 10);
        drive(7'h19, sel(3), 10);
        idle(8);
        check("split dwell no frame", 32'(got_q.size()), 0);
        drive(7'h79, sel(0), 10);
        idle(8);
        expect_frame("split dwell frame", 16'h4321, 1'b0);

        // Back-pressure: second frame dropped, Overrun sticks.
        @(negedge Clk);
        check("overrun before", 32'(Overrun), 0);
        Ready = 1'b0;
        scan4({7'h79, 7'h24, 7'h30, 7'h19}, 10);
        idle(4);
        @(negedge Clk);
        check("bp first Valid", 32'(Valid), 1);
        check("bp first BcdOut", 32'(BcdOut), 32'h1234);
        check("bp first Overrun", 32'(Overrun), 0);
        scan4({7'h12, 7'h02, 7'h78, 7'h00}, 10);
        idle(8);
        @(negedge Clk);
        check("bp held Valid", 32'(Valid), 1);
        check("bp held BcdOut", 32'(BcdOut), 32'h1234);
        check("bp Overrun", 32'(Overrun), 1);
        @(posedge Clk);
        #1;
        Ready = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        check("bp Valid drop", 32'(Valid), 0);
        expect_frame("bp delivered", 16'h1234, 1'b0);
        check("bp dropped frame", 32'(got_q.size()), 0);
        check("bp Overrun sticky", 32'(Overrun), 1);

        // Reset mid-frame discards captured digits.
        Ready = 1'b0;
        scan4(vecs[2].pats, 10);
        drive(7'h40, sel(0), 10);
        drive(7'h79, sel(1), 10);
        drive(7'h24, sel(2), 10);
        @(posedge Clk);
        #3;
        Rst_n = 1'b0;
        SevenSegs = 7'h7F;
        DigitEn = 4'hF;
        #1;
        check("rst BcdOut", 32'(BcdOut), 0);
        check("rst ErrOut", 32'(ErrOut), 0);
        check("rst Valid", 32'(Valid), 0);
        check("rst Overrun", 32'(Overrun), 0);
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("rst hold Valid", 32'(Valid), 0);
        Rst_n = 1'b1;
        Ready = 1'b1;
        drive(7'h30, sel(3), 10);
        idle(8);
        @(negedge Clk);
        check("post-rst no frame", 32'(got_q.size()), 0);
        check("post-rst Valid", 32'(Valid), 0);

        // Random dwells against a dwell-level model.
        @(negedge Clk);
        Rst_n = 1'b0;
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        got_q.delete();
        got_cyc.delete();
        begin
            logic [3:0] m_dig [4];
            logic       m_err [4];
            logic [3:0] m_mask;
            logic [6:0] pool [11];
            logic [6:0] p, pp;
            logic [3:0] en;
            logic [4:0] dn;
            int d, pd, len;
            bit legal, prev_legal;
            pool = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h18, 7'h7F};
            m_mask = '0;
            prev_legal = 0;
            pd = 0;
            pp = '0;
            for (int k = 0; k < 4; k++) begin
                m_dig[k] = '0;
                m_err[k] = 1'b0;
            end
            for (int k = 0; k < 200; k++) begin
                legal = ($urandom_range(0, 9) != 0);
                if (!legal) begin
                    en  = ($urandom_range(0, 1) == 1) ? 4'hF : ~(4'b0011 << $urandom_range(0, 2));
                    p   = 7'($urandom);
                    len = $urandom_range(1, 6);
                end else begin
                    d  = $urandom_range(0, 3);
                    en = sel(d);
                    do begin
                        if ($urandom_range(0, 9) < 3) p = 7'($urandom);
                        else                          p = pool[$urandom_range(0, 10)];
                    end while (prev_legal && d == pd && p == pp);
                    if ($urandom_range(0, 2) == 0) len = $urandom_range(1, SC - 1);
                    else                           len = $urandom_range(SC + 1, SC + 6);
                end
                drive(p, en, len);
                if (legal && len >= SC) begin
                    dn = model_dec(p);
                    m_dig[d] = dn[3:0];
                    m_err[d] = dn[4];
                    m_mask[d] = 1'b1;
                    if (m_mask == 4'hF) begin
                        exp_q.push_back({m_err[0] | m_err[1] | m_err[2] | m_err[3],
                                         m_dig[3], m_dig[2], m_dig[1], m_dig[0]});
                        m_mask = '0;
                        for (int j = 0; j < 4; j++) m_err[j] = 1'b0;
                    end
                end
                prev_legal = legal;
                pd = d;
                pp = p;
            end
            idle(10);
            check("rand frame count", 32'(got_q.size()), 32'(exp_q.size()));
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
                check($sformatf("rand frame %0d", i), 32'(got_q[i]), 32'(exp_q[i]));
            @(negedge Clk);
            check("rand Overrun", 32'(Overrun), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
